vga_wbuf_arbiter: RTL and testbench
===================================

Name: vga_wbuf_arbiter

Overview:
- Owns write port A of the shared 640x480 VGA pixel BRAM.
- Arbitrates pixel writes from the rangefinder plotter and the disparity result writer, selected by display mode.
- Sweeps and clears the buffer after reset, after every mode change and on request.
- Sits between the rangefinder/parallel_disparity write outputs and the BRAM port-A pins (vga_waddr, dina, ena, wea).

Parameters:
- RF_WORDS, 307200, words cleared and addressable in rangefinder/combined modes (640*480).
- DISP_WORDS, 110592, words cleared and addressable in disparity mode (384*288).
- CLEAR_VAL, 8'h00, pixel value written during clear sweeps.

Ports:
- clk  in  1  100MHz BRAM write clock
- reset  in  1  asynchronous, active-low reset
- mode  in  2  0=rangefinder only, 1=disparity only, 2/3=combined (round-robin)
- clear_req  in  1  single-cycle pulse requesting a buffer clear
- rf_valid  in  1  rangefinder write request
- rf_addr  in  19  rangefinder pixel address
- rf_data  in  8  rangefinder pixel data
- rf_ready  out  1  rangefinder request accepted this cycle when rf_valid=1
- dp_valid  in  1  disparity write request
- dp_addr  in  19  disparity pixel address
- dp_data  in  8  disparity pixel data
- dp_ready  out  1  disparity request accepted this cycle when dp_valid=1
- vga_waddr  out  19  BRAM port-A address
- dina  out  8  BRAM port-A data
- ena  out  1  BRAM port-A enable
- wea  out  1  BRAM port-A write enable
- clearing  out  1  high while a clear sweep is active
- drop_count  out  16  saturating count of accepted-but-discarded requests

Behaviour:
- Reset (reset=0, async): all outputs 0; FSM=INIT; mode_q=0; clear counter=0; round-robin pointer=RF.
- FSM states:
  - INIT: one cycle, then CLEAR using the current mode.
  - CLEAR: clearing=1 and both ready=0. Each cycle, register a write of CLEAR_VAL at cnt, then cnt+1. The sweep ends after writing limit-1 (limit=DISP_WORDS for mode 1, else RF_WORDS); then go to RUN.
  - RUN: normal arbitration.
- Mode change: mode_q registers mode each cycle. When mode!=mode_q in any state, go to CLEAR with cnt=0, and the limit follows the new mode.
- clear_req in RUN or CLEAR restarts the sweep from cnt=0. clear_req in the same cycle as a mode change causes a single restart.
- Handshake: a transfer occurs when valid and ready are both high in the same cycle. ready is combinational from state, mode and the valid inputs only.
- RUN arbitration:
  - Mode 0: rf_ready=1, dp_ready=1; dp transfers are discarded.
  - Mode 1: rf_ready=1, dp_ready=1; rf transfers are discarded.
  - Mode 2/3, one valid: that requester gets ready=1.
  - Mode 2/3, both valid: the requester not granted last gets ready=1 and the other gets 0; the pointer updates on each granted transfer.
- Range check: a transfer with addr >= current limit is discarded.
- Discards: accepted (ready=1) but produce no write; drop_count+1, saturating at 16'hFFFF; reset only clears it. Two discards in one cycle (mode 0/1 with both valid, one out-of-range) add 2, saturating.
- Latency: a transfer or clear step in cycle N gives ena=wea=1 with its vga_waddr/dina in cycle N+1. Otherwise ena=wea=0 and vga_waddr/dina hold their last values.
- Throughput: at most one BRAM write per cycle.
- CLEAR entry mid-RUN: a write accepted in the entry cycle still issues next cycle, then the sweep starts.

Test Plan:
- Release reset, mode=0, no requests -> clearing=1; ena=wea=1 with vga_waddr 0..307199 (dina=00) on consecutive cycles; then clearing=0 and rf_ready=1.
- Mode 0 RUN; rf_valid with addr 1234, data FF -> next cycle vga_waddr=1234, dina=FF, ena=wea=1. dp_valid with addr 5 -> dp_ready=1, no write, drop_count=1.
- Switch mode 0->1 during RUN -> clear sweep of exactly 110592 words (last addr 110591), then dp writes pass and rf writes are dropped.
- Mode 2 RUN with rf_valid and dp_valid held high for 6 cycles -> writes alternate DP,RF,DP,RF,DP,RF (pointer starts RF-last after reset); the non-granted ready is 0 each cycle.
- Mode 1 RUN; dp_addr=110592 -> accepted, no write, drop_count+1. Hold both valids until 65536 discards -> drop_count sticks at FFFF.
- Assert reset mid-sweep at cnt=5000 -> all outputs 0 immediately; after release, INIT then the sweep restarts at addr 0. clear_req at cnt=100 -> next write addr 0.

Source files
------------

// File: rtl/vga_wbuf_arbiter.sv
// ---------------------------------------------------------------------------
// vga_wbuf_arbiter
//
// Owns write port A of the shared VGA pixel BRAM. Pixel writes from the
// rangefinder plotter (rf_*) and the disparity result writer (dp_*) are
// arbitrated according to the display mode. The whole active buffer is
// swept with CLEAR_VAL after reset, after every mode change and on request.
//
// Ports:
//   clk          BRAM write clock
//   reset        asynchronous, active-low reset
//   mode         0 = rangefinder, 1 = disparity, 2/3 = combined round-robin
//   clear_req    single-cycle pulse requesting a buffer clear
//   rf_valid/rf_addr/rf_data/rf_ready   rangefinder write handshake
//   dp_valid/dp_addr/dp_data/dp_ready   disparity write handshake
//   vga_waddr/dina/ena/wea              BRAM port-A pins (registered)
//   clearing     high while a clear sweep is running
//   drop_count   saturating count of accepted-but-discarded requests
// ---------------------------------------------------------------------------
module vga_wbuf_arbiter #(
  parameter int unsigned RF_WORDS   = 307200,
  parameter int unsigned DISP_WORDS = 110592,
  parameter logic [7:0]  CLEAR_VAL  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        clear_req,
  input  logic        rf_valid,
  input  logic [18:0] rf_addr,
  input  logic [7:0]  rf_data,
  output logic        rf_ready,
  input  logic        dp_valid,
  input  logic [18:0] dp_addr,
  input  logic [7:0]  dp_data,
  output logic        dp_ready,
  output logic [18:0] vga_waddr,
  output logic [7:0]  dina,
  output logic        ena,
  output logic        wea,
  output logic        clearing,
  output logic [15:0] drop_count
);

  // Limits carry one extra bit so RF_WORDS itself is representable.
  localparam logic [19:0] RF_LIM = 20'(RF_WORDS);
  localparam logic [19:0] DP_LIM = 20'(DISP_WORDS);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  mode_q;
  logic [18:0] cnt_q, cnt_d;
  logic        last_dp_q, last_dp_d;   // 1 = disparity was granted last
  logic [18:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [15:0] drop_q, drop_d;

  logic        combined;
  logic [19:0] limit;
  logic        restart;
  logic        rf_xfer, dp_xfer;
  logic        rf_write, dp_write;
  logic        rf_drop, dp_drop;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  assign combined = mode[1];
  // The limit always follows the live mode input; any mode change restarts
  // the sweep, so a stale limit can never end a sweep early.
  assign limit    = (mode == 2'd1) ? DP_LIM : RF_LIM;
  assign restart  = (mode != mode_q) || clear_req;

  // -------------------------------------------------------------------------
  // Ready generation: combinational from state, mode and the valids only.
  // -------------------------------------------------------------------------
  always_comb begin
    rf_ready = 1'b0;
    dp_ready = 1'b0;
    if (state_q == ST_RUN) begin
      if (!combined) begin
        // Single-source modes accept both sides; the unused one is dropped.
        rf_ready = 1'b1;
        dp_ready = 1'b1;
      end else if (rf_valid && dp_valid) begin
        // Contention: grant whoever was not granted last.
        rf_ready = last_dp_q;
        dp_ready = !last_dp_q;
      end else begin
        rf_ready = rf_valid;
        dp_ready = dp_valid;
      end
    end
  end

  assign rf_xfer  = rf_valid && rf_ready;
  assign dp_xfer  = dp_valid && dp_ready;

  assign rf_write = rf_xfer && (mode != 2'd1) && ({1'b0, rf_addr} < limit);
  assign dp_write = dp_xfer && (mode != 2'd0) && ({1'b0, dp_addr} < limit);
  assign rf_drop  = rf_xfer && !rf_write;
  assign dp_drop  = dp_xfer && !dp_write;

  assign drop_inc = {1'b0, rf_drop} + {1'b0, dp_drop};
  assign drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};

  // -------------------------------------------------------------------------
  // Next-state, write-port and bookkeeping logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_dp_d = last_dp_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wen_d     = 1'b0;
    drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    unique case (state_q)
      ST_INIT: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end

      ST_CLEAR: begin
        if (restart) begin
          // The restart cycle issues no write so that address 0 is the
          // very next word written.
          cnt_d = '0;
        end else begin
          wen_d   = 1'b1;
          waddr_d = cnt_q;
          wdata_d = CLEAR_VAL;
          if ({1'b0, cnt_q} == (limit - 20'd1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 19'd1;
          end
        end
      end

      ST_RUN: begin
        // At most one of rf_write/dp_write can be set in any mode.
        if (rf_write) begin
          wen_d   = 1'b1;
          waddr_d = rf_addr;
          wdata_d = rf_data;
        end else if (dp_write) begin
          wen_d   = 1'b1;
          waddr_d = dp_addr;
          wdata_d = dp_data;
        end
        if (combined) begin
          if (rf_xfer) last_dp_d = 1'b0;
          if (dp_xfer) last_dp_d = 1'b1;
        end
        // A write accepted here still issues next cycle; the sweep follows.
        if (restart) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      mode_q    <= 2'd0;
      cnt_q     <= '0;
      last_dp_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode;
      cnt_q     <= cnt_d;
      last_dp_q <= last_dp_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      drop_q    <= drop_d;
    end
  end

  assign vga_waddr  = waddr_q;
  assign dina       = wdata_q;
  assign ena        = wen_q;
  assign wea        = wen_q;
  assign clearing   = (state_q == ST_CLEAR);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_vga_wbuf_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for vga_wbuf_arbiter. Buffer sizes are shrunk so the
// clear sweeps stay short; expected BRAM writes go into a scoreboard queue
// when stimulus is driven and are popped as the DUT raises ena.
// ---------------------------------------------------------------------------
module tb_vga_wbuf_arbiter;

  localparam int RFW = 64;
  localparam int DPW = 24;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        clear_req = 1'b0;
  logic        rf_valid = 1'b0;
  logic [18:0] rf_addr = '0;
  logic [7:0]  rf_data = '0;
  logic        rf_ready;
  logic        dp_valid = 1'b0;
  logic [18:0] dp_addr = '0;
  logic [7:0]  dp_data = '0;
  logic        dp_ready;
  logic [18:0] vga_waddr;
  logic [7:0]  dina;
  logic        ena;
  logic        wea;
  logic        clearing;
  logic [15:0] drop_count;

  vga_wbuf_arbiter #(
    .RF_WORDS   (RFW),
    .DISP_WORDS (DPW),
    .CLEAR_VAL  (8'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .clear_req  (clear_req),
    .rf_valid   (rf_valid),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .rf_ready   (rf_ready),
    .dp_valid   (dp_valid),
    .dp_addr    (dp_addr),
    .dp_data    (dp_data),
    .dp_ready   (dp_ready),
    .vga_waddr  (vga_waddr),
    .dina       (dina),
    .ena        (ena),
    .wea        (wea),
    .clearing   (clearing),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_drops = 0;
  logic last_dp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({19'(i), 8'h00});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    chk({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic add_drops(input int n);
    exp_drops = exp_drops + n;
    if (exp_drops > 65535) exp_drops = 65535;
  endtask

  // Scoreboard monitor: every BRAM write must match the head of the queue.
  always @(negedge clk) begin
    wr_t e;
    if (reset && ena) begin
      if (exp_q.size() == 0) begin
        chk("wr_pending", exp_q.size(), 1);
        $display("write addr=%0d data=%02h (unexpected)", vga_waddr, dina);
      end else begin
        e = exp_q.pop_front();
        $display("write addr=%0d data=%02h", vga_waddr, dina);
        chk("wr_addr", 32'(vga_waddr), 32'(e.addr));
        chk("wr_data", 32'(dina), 32'(e.data));
        chk("wr_wea", 32'(wea), 1);
      end
    end
  end

  initial begin
    wr_t keep;

    // ---------------- reset state ----------------
    rf_valid = 1'b1;
    dp_valid = 1'b1;
    repeat (3) tick();
    chk("rst_ena", ena, 0);
    chk("rst_wea", wea, 0);
    chk("rst_clearing", clearing, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_waddr", vga_waddr, 0);
    chk("rst_rf_ready", rf_ready, 0);
    chk("rst_dp_ready", dp_ready, 0);
    rf_valid = 1'b0;
    dp_valid = 1'b0;

    // ---------------- power-on sweep (mode 0) ----------------
    push_sweep(RFW);
    reset = 1'b1;
    tick();
    chk("init_clearing", clearing, 1);
    drain("init");
    chk("init_done_clearing", clearing, 0);
    chk("init_rf_ready", rf_ready, 1);

    // ---------------- mode 0 RUN ----------------
    rf_addr = 19'd12; rf_data = 8'hFF; rf_valid = 1'b1;
    exp_q.push_back({19'd12, 8'hFF});
    #1 chk("m0_rf_ready", rf_ready, 1);
    tick();
    rf_addr = 19'd63; rf_data = 8'h3C;      // last in-range word
    exp_q.push_back({19'd63, 8'h3C});
    tick();
    rf_addr = 19'd64;                       // first out-of-range word
    tick();
    rf_valid = 1'b0;
    add_drops(1);
    chk("m0_rf_oor_drop", drop_count, exp_drops);
    dp_addr = 19'd5; dp_data = 8'h77; dp_valid = 1'b1;
    #1 chk("m0_dp_ready", dp_ready, 1);
    tick();
    dp_valid = 1'b0;
    add_drops(1);
    chk("m0_dp_drop", drop_count, exp_drops);
    drain("m0");

    // ---------------- mode 0 -> 1, write accepted in entry cycle ----------------
    mode = 2'd1;
    dp_addr = 19'd3; dp_data = 8'h22; dp_valid = 1'b1;
    exp_q.push_back({19'd3, 8'h22});
    push_sweep(DPW);
    #1 chk("m1_entry_dp_ready", dp_ready, 1);
    tick();
    dp_valid = 1'b0;
    chk("m1_clearing", clearing, 1);
    drain("m1_sweep");
    chk("m1_done_clearing", clearing, 0);

    dp_addr = 19'd23; dp_data = 8'h5A; dp_valid = 1'b1;
    exp_q.push_back({19'd23, 8'h5A});
    tick();
    dp_addr = 19'd24;                       // == DISP_WORDS, out of range
    #1 chk("m1_oor_ready", dp_ready, 1);
    tick();
    dp_valid = 1'b0;
    add_drops(1);
    chk("m1_dp_oor_drop", drop_count, exp_drops);
    rf_addr = 19'd1; rf_data = 8'h99; rf_valid = 1'b1;
    #1 chk("m1_rf_ready", rf_ready, 1);
    tick();
    rf_valid = 1'b0;
    add_drops(1);
    chk("m1_rf_drop", drop_count, exp_drops);
    drain("m1");

    // ---------------- mode 2 round-robin ----------------
    mode = 2'd2;
    push_sweep(RFW);
    tick();
    drain("m2_sweep");
    for (int i = 0; i < 8; i++) begin
      logic exp_rf, exp_dp;
      rf_addr = 19'(10 + i); rf_data = 8'(8'hA0 + i);
      dp_addr = 19'(30 + i); dp_data = 8'(8'hB0 + i);
      rf_valid = 1'b1;
      dp_valid = (i != 6);                  // one cycle with rf alone
      if (dp_valid) begin
        exp_rf = last_dp;
        exp_dp = !last_dp;
      end else begin
        exp_rf = 1'b1;
        exp_dp = 1'b0;
      end
      if (exp_rf) exp_q.push_back({rf_addr, rf_data});
      else        exp_q.push_back({dp_addr, dp_data});
      last_dp = exp_dp;
      #1;
      chk($sformatf("rr%0d_rf_ready", i), rf_ready, exp_rf);
      chk($sformatf("rr%0d_dp_ready", i), dp_ready, exp_dp);
      tick();
    end
    rf_valid = 1'b0;
    dp_valid = 1'b0;
    dp_addr = 19'd64; dp_valid = 1'b1;      // combined mode out of range
    #1 chk("m2_oor_ready", dp_ready, 1);
    tick();
    dp_valid = 1'b0;
    last_dp = 1'b1;
    add_drops(1);
    chk("m2_oor_drop", drop_count, exp_drops);
    drain("m2");

    // ---------------- clear_req in RUN, then again mid-sweep ----------------
    push_sweep(RFW);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("creq_clearing", clearing, 1);
    repeat (10) tick();
    // The word already on the pins stays; the rest of the sweep is replaced.
    keep = exp_q.pop_front();
    exp_q.delete();
    exp_q.push_back(keep);
    push_sweep(RFW);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    drain("creq_restart");

    // ---------------- clear_req together with mode change ----------------
    mode = 2'd0;
    clear_req = 1'b1;
    push_sweep(RFW);
    tick();
    clear_req = 1'b0;
    drain("creq_mode");
    repeat (3) tick();
    chk("creq_mode_no_extra", ena, 0);

    // ---------------- async reset mid-sweep ----------------
    push_sweep(RFW);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (20) tick();
    chk("pre_rst_ena", ena, 1);
    reset = 1'b0;
    #1;
    chk("arst_ena", ena, 0);
    chk("arst_wea", wea, 0);
    chk("arst_clearing", clearing, 0);
    chk("arst_drop", drop_count, 0);
    chk("arst_waddr", vga_waddr, 0);
    exp_q.delete();
    exp_drops = 0;
    last_dp = 1'b0;
    tick();
    push_sweep(RFW);
    reset = 1'b1;
    tick();
    chk("rerst_clearing", clearing, 1);
    drain("rerst");

    // ---------------- drop counter saturation (mode 1) ----------------
    mode = 2'd1;
    push_sweep(DPW);
    tick();
    drain("sat_sweep");
    rf_addr = 19'd0;  rf_valid = 1'b1;      // dropped: wrong source
    dp_addr = 19'd24; dp_valid = 1'b1;      // dropped: out of range
    #1 chk("sat_both_ready", {rf_ready, dp_ready}, 2'b11);
    repeat (32767) tick();
    add_drops(2 * 32767);
    chk("sat_fffe", drop_count, exp_drops);
    rf_valid = 1'b0;
    tick();
    add_drops(1);
    chk("sat_ffff", drop_count, exp_drops);
    rf_valid = 1'b1;
    repeat (3) tick();
    add_drops(6);
    chk("sat_stick", drop_count, exp_drops);
    rf_valid = 1'b0;
    dp_valid = 1'b0;

    repeat (5) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
